// File: rtl/prog_ctr_ras.sv
// Program counter / fetch sequencer with branch conditions and an optional return-address stack.
// Latency: 1 cycle; an op presented in cycle n is visible on ProgCtr after that posedge.
// Backpressure: Start or Stall hold all state; there is no handshake.
// Optional feature macro: PC_RAS_EN (CALL/RET use the stack; undefined -> CALL=JMP, RET=INC).
module prog_ctr_ras #(
  parameter int PC_W      = 10,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic                           Stall,
  input  logic [2:0]                     BrOp,
  input  logic [1:0]                     AluFlag,
  input  logic [PC_W-1:0]                Target,
  output logic [PC_W-1:0]                ProgCtr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] RasDepth,
  output logic                           RasErr
);

  localparam int DW = $clog2(RAS_DEPTH+1);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;
  logic [PC_W-1:0] pc_nxt;
  logic            flag_z;
  logic            flag_n;

  assign pc_inc = ProgCtr + 1'b1;
  assign pc_rel = ProgCtr + Target;
  assign flag_z = AluFlag[1];
  assign flag_n = AluFlag[0];

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_under;
  logic            ras_full;

  // Pointer arithmetic that wraps at RAS_DEPTH, so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RAS_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(RAS_DEPTH-1) : p - 1'b1;
  endfunction

  assign rd_ptr   = ptr_dec(wr_ptr);
  assign ras_full = (RasDepth == DW'(RAS_DEPTH));
`endif

  // Next-PC selection and stack push/pop requests from the flow opcode.
  always_comb begin
    pc_nxt = pc_inc;
`ifdef PC_RAS_EN
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_under = 1'b0;
`endif
    case (BrOp)
      3'b000: pc_nxt = pc_inc;
      3'b001: pc_nxt = Target;
      3'b010: pc_nxt = !flag_z            ? pc_rel : pc_inc;
      3'b011: pc_nxt = flag_n             ? pc_rel : pc_inc;
      3'b100: pc_nxt = (!flag_z && !flag_n) ? pc_rel : pc_inc;
      3'b101: pc_nxt = flag_z             ? pc_rel : pc_inc;
`ifdef PC_RAS_EN
      3'b110: begin
        pc_nxt   = Target;
        ras_push = 1'b1;
      end
      default: begin
        if (RasDepth != '0) begin
          pc_nxt  = ras_mem[rd_ptr];
          ras_pop = 1'b1;
        end else begin
          pc_nxt    = pc_inc;
          ras_under = 1'b1;
        end
      end
`else
      3'b110:  pc_nxt = Target;
      default: pc_nxt = pc_inc;
`endif
    endcase
  end

  // PC register: Reset beats Start beats Stall beats the opcode.
  always_ff @(posedge Clk) begin
    if (Reset)
      ProgCtr <= PC_W'(RESET_PC);
    else if (!Start && !Stall)
      ProgCtr <= pc_nxt;
  end

`ifdef PC_RAS_EN
  // Stack pointer, depth and sticky error; a full push overwrites the oldest slot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr   <= '0;
      RasDepth <= '0;
      RasErr   <= 1'b0;
    end else if (Start) begin
      RasErr <= 1'b0;
    end else if (!Stall) begin
      if (ras_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        if (ras_full)
          RasErr <= 1'b1;
        else
          RasDepth <= RasDepth + 1'b1;
      end else if (ras_pop) begin
        wr_ptr   <= rd_ptr;
        RasDepth <= RasDepth - 1'b1;
      end else if (ras_under) begin
        RasErr <= 1'b1;
      end
    end
  end

  // Return-address storage; contents need no reset since depth gates every read.
  always_ff @(posedge Clk) begin
    if (!Reset && !Start && !Stall && ras_push)
      ras_mem[wr_ptr] <= pc_inc;
  end
`else
  assign RasDepth = '0;
  assign RasErr   = 1'b0;
`endif

endmodule

// File: tb/tb_prog_ctr_ras.sv
// Scoreboard bench for prog_ctr_ras: directed vectors push expected state, a monitor compares.
// Latency: each vector is driven on a negedge and checked 1 time unit after the next posedge.
// Backpressure: none; the monitor checks every cycle that has an expectation queued.
module tb_prog_ctr_ras;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] pc;
    logic [2:0] dep;
    logic       err;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Stall;
  logic [2:0] BrOp;
  logic [1:0] AluFlag;
  logic [9:0] Target;
  logic [9:0] ProgCtr;
  logic [2:0] RasDepth;
  logic       RasErr;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  prog_ctr_ras #(.PC_W(10), .RAS_DEPTH(4), .RESET_PC(0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BrOp(BrOp),
    .AluFlag(AluFlag), .Target(Target), .ProgCtr(ProgCtr),
    .RasDepth(RasDepth), .RasErr(RasErr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: compare registered outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ProgCtr",  (^ProgCtr  === 1'bx) ? -1 : int'(ProgCtr),  int'(e.pc));
        check("RasDepth", (^RasDepth === 1'bx) ? -1 : int'(RasDepth), int'(e.dep));
        check("RasErr",   (RasErr    === 1'bx) ? -1 : int'(RasErr),   int'(e.err));
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic stl, input logic [2:0] op,
                      input logic [1:0] flg, input logic [9:0] tgt,
                      input logic [9:0] epc, input logic [2:0] edep, input logic eerr);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Start = st; Stall = stl; BrOp = op; AluFlag = flg; Target = tgt;
    e.pc = epc; e.dep = edep; e.err = eerr;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BrOp = 3'b000; AluFlag = 2'b00; Target = '0;

    // 1. Reset then counting.
    step(1, 0, 0, 3'b000, 2'b00, 10'd0, 10'd0, 3'd0, 1'b0);
    for (int i = 1; i <= 5; i++)
      step(0, 0, 0, 3'b000, 2'b00, 10'd0, 10'(i), 3'd0, 1'b0);

    // 2. BNE with negative offset.
    step(0, 0, 0, 3'b001, 2'b00, 10'd20,  10'd20, 3'd0, 1'b0);
    step(0, 0, 0, 3'b010, 2'b00, 10'h3FC, 10'd16, 3'd0, 1'b0);
    step(0, 0, 0, 3'b001, 2'b00, 10'd20,  10'd20, 3'd0, 1'b0);
    step(0, 0, 0, 3'b010, 2'b10, 10'h3FC, 10'd21, 3'd0, 1'b0);

    // 3. BGT, BLT, BEQ taken and not taken.
    step(0, 0, 0, 3'b001, 2'b00, 10'd20,  10'd20, 3'd0, 1'b0);
    step(0, 0, 0, 3'b100, 2'b00, 10'h3FC, 10'd16, 3'd0, 1'b0);
    step(0, 0, 0, 3'b001, 2'b00, 10'd20,  10'd20, 3'd0, 1'b0);
    step(0, 0, 0, 3'b100, 2'b01, 10'h3FC, 10'd21, 3'd0, 1'b0);
    step(0, 0, 0, 3'b011, 2'b01, 10'd5,   10'd26, 3'd0, 1'b0);
    step(0, 0, 0, 3'b011, 2'b00, 10'd5,   10'd27, 3'd0, 1'b0);
    step(0, 0, 0, 3'b101, 2'b10, 10'h3FE, 10'd25, 3'd0, 1'b0);
    step(0, 0, 0, 3'b101, 2'b00, 10'h3FE, 10'd26, 3'd0, 1'b0);

    // 4. Single CALL/RET.
    step(0, 0, 0, 3'b001, 2'b00, 10'd5,   10'd5,   3'd0, 1'b0);
    step(0, 0, 0, 3'b110, 2'b00, 10'd100, 10'd100, RAS ? 3'd1 : 3'd0, 1'b0);
    step(0, 0, 0, 3'b111, 2'b00, 10'd0,   RAS ? 10'd6 : 10'd101, 3'd0, 1'b0);

    // 5. Overflow, innermost-first returns, underflow, Start clears error.
    step(0, 0, 0, 3'b001, 2'b00, 10'd200, 10'd200, 3'd0, 1'b0);
    step(0, 0, 0, 3'b110, 2'b00, 10'd300, 10'd300, RAS ? 3'd1 : 3'd0, 1'b0);
    step(0, 0, 0, 3'b110, 2'b00, 10'd400, 10'd400, RAS ? 3'd2 : 3'd0, 1'b0);
    step(0, 0, 0, 3'b110, 2'b00, 10'd500, 10'd500, RAS ? 3'd3 : 3'd0, 1'b0);
    step(0, 0, 0, 3'b110, 2'b00, 10'd600, 10'd600, RAS ? 3'd4 : 3'd0, 1'b0);
    step(0, 0, 0, 3'b110, 2'b00, 10'd700, 10'd700, RAS ? 3'd4 : 3'd0, RAS);
    step(0, 0, 0, 3'b111, 2'b00, 10'd0, RAS ? 10'd601 : 10'd701, RAS ? 3'd3 : 3'd0, RAS);
    step(0, 0, 0, 3'b111, 2'b00, 10'd0, RAS ? 10'd501 : 10'd702, RAS ? 3'd2 : 3'd0, RAS);
    step(0, 0, 0, 3'b111, 2'b00, 10'd0, RAS ? 10'd401 : 10'd703, RAS ? 3'd1 : 3'd0, RAS);
    step(0, 0, 0, 3'b111, 2'b00, 10'd0, RAS ? 10'd301 : 10'd704, 3'd0, RAS);
    step(0, 0, 0, 3'b111, 2'b00, 10'd0, RAS ? 10'd302 : 10'd705, 3'd0, RAS);
    step(0, 1, 0, 3'b001, 2'b00, 10'd9, RAS ? 10'd302 : 10'd705, 3'd0, 1'b0);

    // 6. Stall holds PC and stack, INC wrap, rel wrap, Start hold, Reset mid-chain.
    step(0, 0, 0, 3'b001, 2'b00, 10'd10, 10'd10, 3'd0, 1'b0);
    step(0, 0, 0, 3'b110, 2'b00, 10'd40, 10'd40, RAS ? 3'd1 : 3'd0, 1'b0);
    step(0, 0, 1, 3'b001, 2'b00, 10'd50, 10'd40, RAS ? 3'd1 : 3'd0, 1'b0);
    step(0, 0, 1, 3'b111, 2'b00, 10'd50, 10'd40, RAS ? 3'd1 : 3'd0, 1'b0);
    step(0, 0, 0, 3'b111, 2'b00, 10'd0, RAS ? 10'd11 : 10'd41, 3'd0, 1'b0);
    step(0, 0, 0, 3'b001, 2'b00, 10'h3FF, 10'h3FF, 3'd0, 1'b0);
    step(0, 0, 0, 3'b000, 2'b00, 10'd0,   10'd0,   3'd0, 1'b0);
    step(0, 0, 0, 3'b101, 2'b10, 10'h3FC, 10'h3FC, 3'd0, 1'b0);
    step(0, 0, 0, 3'b110, 2'b00, 10'd77,  10'd77,  RAS ? 3'd1 : 3'd0, 1'b0);
    step(0, 1, 0, 3'b111, 2'b00, 10'd0,   10'd77,  RAS ? 3'd1 : 3'd0, 1'b0);
    step(0, 0, 0, 3'b110, 2'b00, 10'd88,  10'd88,  RAS ? 3'd2 : 3'd0, 1'b0);
    step(1, 0, 0, 3'b110, 2'b00, 10'd99,  10'd0,   3'd0, 1'b0);
    step(0, 0, 0, 3'b111, 2'b00, 10'd0,   10'd1,   3'd0, RAS);
    step(1, 1, 0, 3'b001, 2'b00, 10'd33,  10'd0,   3'd0, 1'b0);
    step(0, 0, 0, 3'b000, 2'b00, 10'd0,   10'd1,   3'd0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
